// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared control-word layout, register/forwarding types and the hazard match helper.
// Latency: none (declarations only); no flow control.
package ctrl_pkg;

    localparam int CTRL_W = 11;
    localparam int REG_AW = 3;

    localparam int B_SPARE      = 10;
    localparam int B_REG_WRITE  = 9;
    localparam int B_ALU_SRC    = 8;
    localparam int B_MEM_WRITE  = 7;
    localparam int B_ALUOP_HI   = 6;
    localparam int B_ALUOP_LO   = 4;
    localparam int B_MEM_READ   = 3;
    localparam int B_MEM_TO_REG = 2;
    localparam int B_BRANCH     = 1;
    localparam int B_REG_DST    = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;
    typedef logic [REG_AW-1:0] reg_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    localparam ctrl_t BUBBLE = '0;

    // r0 is hardwired zero, so a write to it can never feed a younger reader.
    function automatic logic hits(input logic wr, input reg_t dst, input reg_t a, input reg_t b);
        return wr && (dst != '0) && ((dst == a) || (dst == b));
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// ID-side/datapath-side bundle of the control pipeline: master drives the ID inputs, slave is the pipeline.
// Latency: none (wiring only); no flow control.
interface ctrl_pipe_hazard_if;
    import ctrl_pkg::*;

    ctrl_t      ctrl_id;
    reg_t       id_rs;
    reg_t       id_rt;
    reg_t       id_rd;
    logic       ex_zero;
    logic [2:0] ex_alu_op;
    logic       ex_alu_src;
    logic       ex_branch;
    logic       mem_read;
    logic       mem_write;
    logic       wb_reg_write;
    logic       wb_mem_to_reg;
    reg_t       wb_dst;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       branch_taken;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output ctrl_id, id_rs, id_rt, id_rd, ex_zero,
        input  ex_alu_op, ex_alu_src, ex_branch, mem_read, mem_write,
        input  wb_reg_write, wb_mem_to_reg, wb_dst,
        input  pc_write, ifid_write, ifid_flush, branch_taken, fwd_a, fwd_b
    );

    modport slave (
        input  ctrl_id, id_rs, id_rt, id_rd, ex_zero,
        output ex_alu_op, ex_alu_src, ex_branch, mem_read, mem_write,
        output wb_reg_write, wb_mem_to_reg, wb_dst,
        output pc_write, ifid_write, ifid_flush, branch_taken, fwd_a, fwd_b
    );
endinterface

// File: rtl/ctrl_pipe_hazard_hazard_detect.sv
// Combinational stall/flush/forward decisions; FWD_EN selects forwarding instead of RAW stalls.
// Latency: 0 cycles; backpressure is expressed by dropping pc_write/ifid_write.
module hazard_detect
    import ctrl_pkg::*;
(
    input  logic       i_idex_rw,
    input  logic       i_idex_mr,
    input  logic       i_idex_br,
    input  reg_t       i_idex_rs,
    input  reg_t       i_idex_rt,
    input  reg_t       i_idex_dst,
    input  logic       i_exmem_rw,
    input  reg_t       i_exmem_dst,
    input  logic       i_memwb_rw,
    input  reg_t       i_memwb_dst,
    input  reg_t       i_id_rs,
    input  reg_t       i_id_rt,
    input  logic       i_ex_zero,
    output logic       o_pc_write,
    output logic       o_ifid_write,
    output logic       o_ifid_flush,
    output logic       o_branch_taken,
    output logic       o_idex_bubble,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);
    logic w_load_use;
    logic w_stall;
    logic w_unused_fwd;

    assign w_load_use = hits(i_idex_mr, i_idex_dst, i_id_rs, i_id_rt);

`ifdef FWD_EN
    assign w_stall      = w_load_use;
    assign w_unused_fwd = i_idex_rw;

    // EX/MEM is the younger producer, so its match overrides MEM/WB.
    always_comb begin
        o_fwd_a = FWD_NONE;
        o_fwd_b = FWD_NONE;
        if (hits(i_memwb_rw, i_memwb_dst, i_idex_rs, i_idex_rs)) o_fwd_a = FWD_MEMWB;
        if (hits(i_exmem_rw, i_exmem_dst, i_idex_rs, i_idex_rs)) o_fwd_a = FWD_EXMEM;
        if (hits(i_memwb_rw, i_memwb_dst, i_idex_rt, i_idex_rt)) o_fwd_b = FWD_MEMWB;
        if (hits(i_exmem_rw, i_exmem_dst, i_idex_rt, i_idex_rt)) o_fwd_b = FWD_EXMEM;
    end
`else
    assign w_stall = w_load_use
                   | hits(i_idex_rw,  i_idex_dst,  i_id_rs, i_id_rt)
                   | hits(i_exmem_rw, i_exmem_dst, i_id_rs, i_id_rt)
                   | hits(i_memwb_rw, i_memwb_dst, i_id_rs, i_id_rt);
    assign o_fwd_a      = FWD_NONE;
    assign o_fwd_b      = FWD_NONE;
    assign w_unused_fwd = ^{i_idex_rs, i_idex_rt};
`endif

    // A taken branch kills the ID instruction anyway, so a coincident stall is moot.
    assign o_branch_taken = i_idex_br & ~i_ex_zero;
    assign o_ifid_flush   = o_branch_taken;
    assign o_pc_write     = o_branch_taken | ~w_stall;
    assign o_ifid_write   = o_branch_taken | ~w_stall;
    assign o_idex_bubble  = o_branch_taken | w_stall;

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ID/EX, EX/MEM, MEM/WB control registers with hazard handling; FWD_EN enables forwarding selects.
// Latency ID->WB 3 cycles; no backpressure input, stalls/flushes are issued upstream via pc_write/ifid_*.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    ctrl_pipe_hazard_if.slave bus
);
    ctrl_t r_idex_ctrl;
    reg_t  r_idex_rs;
    reg_t  r_idex_rt;
    reg_t  r_idex_rd;
    ctrl_t r_exmem_ctrl;
    reg_t  r_exmem_dst;
    ctrl_t r_memwb_ctrl;
    reg_t  r_memwb_dst;

    reg_t  w_idex_dst;
    logic  w_idex_bubble;
    logic  w_unused_memwb;

    assign w_idex_dst = r_idex_ctrl[B_REG_DST] ? r_idex_rd : r_idex_rt;

    hazard_detect u_hazard (
        .i_idex_rw      (r_idex_ctrl[B_REG_WRITE]),
        .i_idex_mr      (r_idex_ctrl[B_MEM_READ]),
        .i_idex_br      (r_idex_ctrl[B_BRANCH]),
        .i_idex_rs      (r_idex_rs),
        .i_idex_rt      (r_idex_rt),
        .i_idex_dst     (w_idex_dst),
        .i_exmem_rw     (r_exmem_ctrl[B_REG_WRITE]),
        .i_exmem_dst    (r_exmem_dst),
        .i_memwb_rw     (r_memwb_ctrl[B_REG_WRITE]),
        .i_memwb_dst    (r_memwb_dst),
        .i_id_rs        (bus.id_rs),
        .i_id_rt        (bus.id_rt),
        .i_ex_zero      (bus.ex_zero),
        .o_pc_write     (bus.pc_write),
        .o_ifid_write   (bus.ifid_write),
        .o_ifid_flush   (bus.ifid_flush),
        .o_branch_taken (bus.branch_taken),
        .o_idex_bubble  (w_idex_bubble),
        .o_fwd_a        (bus.fwd_a),
        .o_fwd_b        (bus.fwd_b)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idex_ctrl  <= BUBBLE;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_rd    <= '0;
            r_exmem_ctrl <= BUBBLE;
            r_exmem_dst  <= '0;
            r_memwb_ctrl <= BUBBLE;
            r_memwb_dst  <= '0;
        end else begin
            if (w_idex_bubble) begin
                r_idex_ctrl <= BUBBLE;
                r_idex_rs   <= '0;
                r_idex_rt   <= '0;
                r_idex_rd   <= '0;
            end else begin
                r_idex_ctrl <= bus.ctrl_id;
                r_idex_rs   <= bus.id_rs;
                r_idex_rt   <= bus.id_rt;
                r_idex_rd   <= bus.id_rd;
            end
            r_exmem_ctrl <= r_idex_ctrl;
            r_exmem_dst  <= w_idex_dst;
            r_memwb_ctrl <= r_exmem_ctrl;
            r_memwb_dst  <= r_exmem_dst;
        end
    end

    assign bus.ex_alu_op     = r_idex_ctrl[B_ALUOP_HI:B_ALUOP_LO];
    assign bus.ex_alu_src    = r_idex_ctrl[B_ALU_SRC];
    assign bus.ex_branch     = r_idex_ctrl[B_BRANCH];
    assign bus.mem_read      = r_exmem_ctrl[B_MEM_READ];
    assign bus.mem_write     = r_exmem_ctrl[B_MEM_WRITE];
    assign bus.wb_reg_write  = r_memwb_ctrl[B_REG_WRITE];
    assign bus.wb_mem_to_reg = r_memwb_ctrl[B_MEM_TO_REG];
    assign bus.wb_dst        = r_memwb_dst;

    // Fields already consumed upstream ride along to WB but are not needed there.
    assign w_unused_memwb = ^{r_memwb_ctrl[B_SPARE],
                              r_memwb_ctrl[B_ALU_SRC:B_MEM_READ],
                              r_memwb_ctrl[B_BRANCH:B_REG_DST]};

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed vector table for ctrl_pipe_hazard plus a hand sequence for reset during a branch flush.
module tb_ctrl_pipe_hazard;

    localparam logic [10:0] NOP = 11'h000;
    localparam logic [10:0] ADD = 11'h221;
    localparam logic [10:0] AND = 11'h231;
    localparam logic [10:0] SUB = 11'h261;
    localparam logic [10:0] LW  = 11'h32C;
    localparam logic [10:0] SW  = 11'h1A0;
    localparam logic [10:0] BNE = 11'h062;
    localparam logic [10:0] LWB = 11'h32E;

    typedef struct {
        int          grp;
        logic        rst;
        logic [10:0] ctrl;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic        zero;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ctrl_pipe_hazard_if bus();

    ctrl_pipe_hazard dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected order: pcw ifw flush bt | aluop alusrc br | mr mw | rw m2r wd | fwd_a fwd_b
    function automatic void add(input int g, input int r, input logic [10:0] c,
                                input int s, input int t, input int d, input int z,
                                input int pcw, input int ifw, input int fl, input int bt,
                                input int op, input int as, input int br, input int mr, input int mw,
                                input int rw, input int m2r, input int wd, input int fa, input int fb);
        vec_t v;
        v.grp  = g;
        v.rst  = 1'(r);
        v.ctrl = c;
        v.rs   = 3'(s);
        v.rt   = 3'(t);
        v.rd   = 3'(d);
        v.zero = 1'(z);
        v.exp  = {1'(pcw), 1'(ifw), 1'(fl), 1'(bt), 3'(op), 1'(as), 1'(br),
                  1'(mr), 1'(mw), 1'(rw), 1'(m2r), 3'(wd), 2'(fa), 2'(fb)};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, got, want);
    endtask

    task automatic drive(input logic r, input logic [10:0] c, input logic [2:0] s,
                         input logic [2:0] t, input logic [2:0] d, input logic z);
        rst         = r;
        bus.ctrl_id = c;
        bus.id_rs   = s;
        bus.id_rt   = t;
        bus.id_rd   = d;
        bus.ex_zero = z;
    endtask

    initial begin
        logic [19:0] act;
        drive(1'b1, NOP, 3'd0, 3'd0, 3'd0, 1'b0);

        // 1: ADD r1 ; AND r2,r1,r5
`ifdef FWD_EN
        add(1,0,ADD,0,0,1,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(1,0,AND,1,5,2,0, 1,1,0,0, 2,0,0,0,0, 0,0,0, 0,0);
        add(1,0,NOP,0,0,0,0, 1,1,0,0, 3,0,0,0,0, 0,0,0, 2,0);
        add(1,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 1,0,1, 0,0);
        add(1,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 1,0,2, 0,0);
`else
        add(1,0,ADD,0,0,1,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(1,0,AND,1,5,2,0, 0,0,0,0, 2,0,0,0,0, 0,0,0, 0,0);
        add(1,0,AND,1,5,2,0, 0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(1,0,AND,1,5,2,0, 0,0,0,0, 0,0,0,0,0, 1,0,1, 0,0);
        add(1,0,AND,1,5,2,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(1,0,NOP,0,0,0,0, 1,1,0,0, 3,0,0,0,0, 0,0,0, 0,0);
        add(1,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(1,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 1,0,2, 0,0);
`endif
        // 2: LW r3 ; SUB r4,r3,r5
`ifdef FWD_EN
        add(2,0,LW ,0,3,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(2,0,SUB,3,5,4,0, 0,0,0,0, 2,1,0,0,0, 0,0,0, 0,0);
        add(2,0,SUB,3,5,4,0, 1,1,0,0, 0,0,0,1,0, 0,0,0, 0,0);
        add(2,0,NOP,0,0,0,0, 1,1,0,0, 6,0,0,0,0, 1,1,3, 1,0);
        add(2,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(2,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 1,0,4, 0,0);
`else
        add(2,0,LW ,0,3,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(2,0,SUB,3,5,4,0, 0,0,0,0, 2,1,0,0,0, 0,0,0, 0,0);
        add(2,0,SUB,3,5,4,0, 0,0,0,0, 0,0,0,1,0, 0,0,0, 0,0);
        add(2,0,SUB,3,5,4,0, 0,0,0,0, 0,0,0,0,0, 1,1,3, 0,0);
        add(2,0,SUB,3,5,4,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(2,0,NOP,0,0,0,0, 1,1,0,0, 6,0,0,0,0, 0,0,0, 0,0);
        add(2,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(2,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 1,0,4, 0,0);
`endif
        // 3: taken BNE, shadow ADD r6 flushed, target ADD r7
        add(3,0,BNE,1,2,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(3,0,ADD,0,0,6,0, 1,1,1,1, 6,0,1,0,0, 0,0,0, 0,0);
        add(3,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(3,0,ADD,0,0,7,0, 1,1,0,0, 0,0,0,0,0, 0,0,2, 0,0);
        add(3,0,NOP,0,0,0,0, 1,1,0,0, 2,0,0,0,0, 0,0,0, 0,0);
        add(3,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(3,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 1,0,7, 0,0);
        // 4: not-taken BNE
        add(4,0,BNE,1,2,0,1, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(4,0,ADD,0,0,6,1, 1,1,0,0, 6,0,1,0,0, 0,0,0, 0,0);
        add(4,0,NOP,0,0,0,1, 1,1,0,0, 2,0,0,0,0, 0,0,0, 0,0);
        add(4,0,NOP,0,0,0,1, 1,1,0,0, 0,0,0,0,0, 0,0,2, 0,0);
        add(4,0,NOP,0,0,0,1, 1,1,0,0, 0,0,0,0,0, 1,0,6, 0,0);
        // 5: load-use coincident with taken branch
        add(5,0,LWB,0,3,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(5,0,SUB,3,5,4,0, 1,1,1,1, 2,1,1,0,0, 0,0,0, 0,0);
        add(5,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,1,0, 0,0,0, 0,0);
        add(5,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 1,1,3, 0,0);
        // 6: reset during load-use stall, then SW
        add(6,0,LW ,0,3,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(6,1,SUB,3,5,4,0, 0,0,0,0, 2,1,0,0,0, 0,0,0, 0,0);
        add(6,0,SW ,0,6,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,0, 0,0);
        add(6,0,NOP,0,0,0,0, 1,1,0,0, 2,1,0,0,0, 0,0,0, 0,0);
        add(6,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,1, 0,0,0, 0,0);
        add(6,0,NOP,0,0,0,0, 1,1,0,0, 0,0,0,0,0, 0,0,6, 0,0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].zero);
            #2;
            act = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.branch_taken,
                   bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch, bus.mem_read, bus.mem_write,
                   bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_dst, bus.fwd_a, bus.fwd_b};
            n_chk++;
            if (act === vecs[i].exp) n_pass++;
            else $display("FAIL vec%0d grp%0d: outputs %b required %b", i, vecs[i].grp, act, vecs[i].exp);
        end

        // Reset arriving in the same cycle as a taken-branch flush
        @(negedge clk);
        drive(1'b0, BNE, 3'd1, 3'd2, 3'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, ADD, 3'd0, 3'd0, 3'd6, 1'b0);
        #2;
        chk("rstflush_bt",    32'(bus.branch_taken), 32'd1);
        chk("rstflush_flush", 32'(bus.ifid_flush),   32'd1);
        @(negedge clk);
        drive(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0);
        #2;
        chk("rstflush_exbr",  32'(bus.ex_branch),    32'd0);
        chk("rstflush_bt0",   32'(bus.branch_taken), 32'd0);
        chk("rstflush_pcw",   32'(bus.pc_write),     32'd1);
        chk("rstflush_aluop", 32'(bus.ex_alu_op),    32'd0);
        @(negedge clk);
        #2;
        chk("rstflush_mr",    32'(bus.mem_read),     32'd0);
        chk("rstflush_flush0",32'(bus.ifid_flush),   32'd0);
        @(negedge clk);
        #2;
        chk("rstflush_wbrw",  32'(bus.wb_reg_write), 32'd0);
        chk("rstflush_wbdst", 32'(bus.wb_dst),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
